ms72xx_pll_model: RTL and testbench

Synthesizable behavioural stand-in for the board PLL on the ms72xx clocking path. It takes the 50 MHz reference clock and produces one derived output clock, clkout0, as an integer divide of the reference with programmable duty and phase. pll_lock asserts once after a fixed settling interval and stays high until reset. Downstream logic (e.g. the Ethernet datapath) waits for pll_lock before using clkout0.

---
 rtl/ms72xx_pll_model.sv | 91 +++++++++
 tb/tb_ms72xx_pll_model.sv | 118 +++++++++++
 2 files changed

// File: rtl/ms72xx_pll_model.sv
`default_nettype none
// ============================================================================
// Module   : ms72xx_pll_model
// Purpose  : Behavioural PLL stand-in: clkin1 divided to clkout0, sticky lock.
// Revision : 1.0
// ============================================================================
module ms72xx_pll_model #(
    parameter real CLKIN_FREQ    = 50.0,
    parameter int  CLKOUT0_DIV   = 2,
    parameter int  CLKOUT0_DUTY  = 1,
    parameter int  CLKOUT0_PHASE = 0,
    parameter int  LOCK_CYCLES   = 1024
) (
    input  logic clkin1,
    input  logic rst_n,
    output logic clkout0,
    output logic pll_lock
);

    localparam int c_LOCK_W = $clog2(LOCK_CYCLES + 1);
    localparam int c_DIV_W  = $clog2(CLKOUT0_DIV);
    localparam int c_POS_W  = $clog2(2 * CLKOUT0_DIV);

    localparam logic [c_LOCK_W-1:0] c_LOCK_LAST = c_LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(CLKOUT0_DIV - 1);
    localparam logic [c_POS_W-1:0]  c_DIV_POS   = c_POS_W'(CLKOUT0_DIV);
    localparam logic [c_POS_W-1:0]  c_PHASE_POS = c_POS_W'(CLKOUT0_PHASE);
    localparam logic [c_POS_W-1:0]  c_DUTY_POS  = c_POS_W'(CLKOUT0_DUTY);

    // Reject unbuildable configurations before any logic is generated.
    if (CLKIN_FREQ <= 0.0) begin : g_chk_freq
        $error("ms72xx_pll_model: CLKIN_FREQ must be positive");
    end
    if (CLKOUT0_DIV < 2) begin : g_chk_div
        $error("ms72xx_pll_model: CLKOUT0_DIV must be >= 2");
    end
    if ((CLKOUT0_DUTY < 1) || (CLKOUT0_DUTY > CLKOUT0_DIV - 1)) begin : g_chk_duty
        $error("ms72xx_pll_model: CLKOUT0_DUTY out of range");
    end
    if ((CLKOUT0_PHASE < 0) || (CLKOUT0_PHASE >= CLKOUT0_DIV)) begin : g_chk_phase
        $error("ms72xx_pll_model: CLKOUT0_PHASE out of range");
    end
    if (LOCK_CYCLES < 1) begin : g_chk_lock
        $error("ms72xx_pll_model: LOCK_CYCLES must be >= 1");
    end

    logic [c_LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic                lock_q,     lock_d;
    logic [c_DIV_W-1:0]  div_cnt_q,  div_cnt_d;
    logic                clkout_q,   clkout_d;
    logic [c_POS_W-1:0]  w_sum;
    logic [c_POS_W-1:0]  w_pos;

    // One extra bit keeps div_cnt + PHASE from wrapping before the modulo.
    assign w_sum = c_POS_W'(div_cnt_q) + c_PHASE_POS;
    assign w_pos = (w_sum >= c_DIV_POS) ? (w_sum - c_DIV_POS) : w_sum;

    always_comb begin
        lock_cnt_d = lock_cnt_q;
        lock_d     = lock_q;
        div_cnt_d  = '0;
        clkout_d   = lock_q & (w_pos < c_DUTY_POS);
        if (!lock_q) begin
            lock_cnt_d = lock_cnt_q + c_LOCK_W'(1);
            if (lock_cnt_q == c_LOCK_LAST) begin
                lock_d = 1'b1;
            end
        end else begin
            div_cnt_d = (div_cnt_q == c_DIV_LAST) ? '0 : (div_cnt_q + c_DIV_W'(1));
        end
    end

    always_ff @(posedge clkin1 or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt_q <= '0;
            lock_q     <= 1'b0;
            div_cnt_q  <= '0;
            clkout_q   <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            lock_q     <= lock_d;
            div_cnt_q  <= div_cnt_d;
            clkout_q   <= clkout_d;
        end
    end

    assign clkout0  = clkout_q;
    assign pll_lock = lock_q;

endmodule
`default_nettype wire

// File: tb/tb_ms72xx_pll_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_ms72xx_pll_model
// Purpose  : Randomised reset/run epochs on four PLL configurations vs model.
// Revision : 1.0
// ============================================================================
module tb_ms72xx_pll_model;

    logic clkin1 = 1'b0;
    logic rst_n  = 1'b1;

    logic clk_def, lock_def;
    logic clk_d5,  lock_d5;
    logic clk_d4,  lock_d4;
    logic clk_l1,  lock_l1;

    int vectors     = 0;
    int miscompares = 0;
    int k           = 0;
    int rises       = 0;
    int falls       = 0;
    int exp_rises   = 0;
    int exp_falls   = 0;

    always #10 clkin1 = ~clkin1;

    ms72xx_pll_model u_def (
        .clkin1(clkin1), .rst_n(rst_n), .clkout0(clk_def), .pll_lock(lock_def)
    );
    ms72xx_pll_model #(.CLKOUT0_DIV(5), .CLKOUT0_DUTY(2), .CLKOUT0_PHASE(0)) u_d5 (
        .clkin1(clkin1), .rst_n(rst_n), .clkout0(clk_d5), .pll_lock(lock_d5)
    );
    ms72xx_pll_model #(.CLKOUT0_DIV(4), .CLKOUT0_DUTY(2), .CLKOUT0_PHASE(1)) u_d4 (
        .clkin1(clkin1), .rst_n(rst_n), .clkout0(clk_d4), .pll_lock(lock_d4)
    );
    ms72xx_pll_model #(.LOCK_CYCLES(1)) u_l1 (
        .clkin1(clkin1), .rst_n(rst_n), .clkout0(clk_l1), .pll_lock(lock_l1)
    );

    always @(posedge lock_def) rises++;
    always @(negedge lock_def) falls++;

    // k = rising edges seen since reset release. Lock is due on edge L; the
    // waveform starts on edge L+1 at phase offset PHASE.
    function automatic logic exp_lock(input int kk, input int l);
        return logic'(kk >= l);
    endfunction

    function automatic logic exp_clk(input int kk, input int l, input int div,
                                     input int duty, input int phase);
        if (kk <= l) return 1'b0;
        return logic'(((kk - l - 1 + phase) % div) < duty);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d (edge %0d, t=%0t)", tag, obs, exp, k, $time);
        end
    endtask

    task automatic check_all();
        check("def.lock", 32'(lock_def), 32'(exp_lock(k, 1024)));
        check("def.clk",  32'(clk_def),  32'(exp_clk(k, 1024, 2, 1, 0)));
        check("d5.lock",  32'(lock_d5),  32'(exp_lock(k, 1024)));
        check("d5.clk",   32'(clk_d5),   32'(exp_clk(k, 1024, 5, 2, 0)));
        check("d4.lock",  32'(lock_d4),  32'(exp_lock(k, 1024)));
        check("d4.clk",   32'(clk_d4),   32'(exp_clk(k, 1024, 4, 2, 1)));
        check("l1.lock",  32'(lock_l1),  32'(exp_lock(k, 1)));
        check("l1.clk",   32'(clk_l1),   32'(exp_clk(k, 1, 2, 1, 0)));
    endtask

    task automatic step();
        @(posedge clkin1);
        if (rst_n) k++;
        #1 check_all();
    endtask

    initial begin
        int run;
        #2 rst_n = 1'b0;
        k = 0;
        #3 check_all();
        @(negedge clkin1);
        rst_n = 1'b1;
        k = 0;

        for (int e = 0; e < 4; e++) begin
            // Epoch 1 is cut short to exercise a reset during the lock wait.
            run = (e == 1) ? int'($urandom_range(200, 900))
                           : 1024 + int'($urandom_range(20, 120));
            repeat (run) step();
            if (k >= 1024) exp_rises++;
            if (e < 3) begin
                if (k >= 1024) exp_falls++;
                step();
                #($urandom_range(1, 7));
                rst_n = 1'b0;
                k = 0;
                #1 check_all();
                repeat (2) step();
                @(negedge clkin1);
                rst_n = 1'b1;
                k = 0;
            end
        end

        #1;
        check("def.lock_rises", 32'(rises), 32'(exp_rises));
        check("def.lock_falls", 32'(falls), 32'(exp_falls));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
